// File: rtl/led_pattern_scheduler_pkg.sv
// Shared encodings for the LED pattern scheduler: pattern modes,
// arbiter states and the LED bus width.
package led_pkg;

    localparam int LED_W = 8;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_COUNT  = 2'b01;
    localparam logic [1:0] MODE_SHIFT  = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    typedef enum logic {
        ST_AUTO     = 1'b0,
        ST_OVERRIDE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/led_pattern_scheduler_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick is high for the whole cycle the
// count sits at its terminal value. clr restarts the count at 0.
module tick_prescaler #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_scheduler.sv
// Drives the LEDs_mgmt input bus from either the timed pattern engine or a
// held external override, arbitrated by a two-state FSM.
module led_pattern_scheduler
    import led_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             mode_valid,
    input  logic [LED_W-1:0] static_val,
    input  logic             req_valid,
    input  logic [LED_W-1:0] req_data,
    input  logic [7:0]       req_hold,
    output logic             req_ready,
    output logic [LED_W-1:0] led_in,
    output logic             busy,
    output logic             tick
);

    logic [1:0]       mode_q;
    logic [LED_W-1:0] cnt_q;
    logic [LED_W-1:0] shift_q;
    logic [LED_W-1:0] shift_d;
    logic             dir_right_q;
    logic             phase_on_q;
    logic [LED_W-1:0] pattern;

    arb_state_e       state_q;
    logic [LED_W-1:0] led_q;
    logic             busy_q;
    logic             ready_q;
    logic [7:0]       hold_q;
    logic [7:0]       hold_d;

    // A mode load restarts the tick period along with the pattern.
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mode_valid),
        .tick  (tick)
    );

    always_comb begin
        shift_d = dir_right_q ? (shift_q >> 1) : (shift_q << 1);
        case (mode_q)
            MODE_COUNT: pattern = cnt_q;
            MODE_SHIFT: pattern = shift_q;
            MODE_BLINK: pattern = phase_on_q ? static_val : '0;
            default:    pattern = static_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_STATIC;
            cnt_q       <= '0;
            shift_q     <= 8'h01;
            dir_right_q <= 1'b0;
            phase_on_q  <= 1'b1;
        end else if (mode_valid) begin
            mode_q      <= mode;
            cnt_q       <= '0;
            shift_q     <= 8'h01;
            dir_right_q <= 1'b0;
            phase_on_q  <= 1'b1;
        end else if (tick) begin
            case (mode_q)
                MODE_COUNT: cnt_q <= cnt_q + 1'b1;
                MODE_SHIFT: begin
                    shift_q <= shift_d;
                    // Turn around on arrival so each endpoint shows for one tick.
                    if (shift_d == 8'h80) begin
                        dir_right_q <= 1'b1;
                    end else if (shift_d == 8'h01) begin
                        dir_right_q <= 1'b0;
                    end
                end
                MODE_BLINK: phase_on_q <= ~phase_on_q;
                default: ;
            endcase
        end
    end

    assign hold_d = (req_hold == 8'd0) ? 8'd1 : req_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_AUTO;
            led_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            case (state_q)
                ST_AUTO: begin
                    if (req_valid && ready_q) begin
                        state_q <= ST_OVERRIDE;
                        led_q   <= req_data;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        hold_q  <= hold_d;
                    end else begin
                        led_q   <= pattern;
                        ready_q <= 1'b1;
                    end
                end
                ST_OVERRIDE: begin
                    if (tick) begin
                        if (hold_q == 8'd1) begin
                            state_q <= ST_AUTO;
                            led_q   <= pattern;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            hold_q  <= hold_q - 8'd1;
                        end
                    end
                end
                default: state_q <= ST_AUTO;
            endcase
        end
    end

    assign led_in    = led_q;
    assign busy      = busy_q;
    assign req_ready = ready_q;

endmodule

// File: doc/led_pattern_scheduler.md
Name: led_pattern_scheduler

Overview:
Sequencer that owns the 8-bit input bus of LEDs_mgmt.
It generates timed LED patterns (static, counter, bouncing one-hot, blink) from a tick prescaler.
It arbitrates that bus between the internal pattern engine and an external override requester, using a valid/ready handshake and a tick-counted hold time.
It sits between user controls (switches, buttons, host logic) and LEDs_mgmt.

Parameters:
TICK_DIV, 25000000, clk cycles per pattern tick (0.5 s at 50 MHz); legal range >= 2; benches use 4.

Ports:
clk  in  1  system clock, rising edge; single clock domain
rst_n  in  1  asynchronous active-low reset
mode  in  2  pattern select: 00 STATIC, 01 COUNT, 10 SHIFT, 11 BLINK
mode_valid  in  1  one-cycle strobe that loads mode
static_val  in  8  live value used by STATIC and BLINK
req_valid  in  1  override request
req_data  in  8  override LED value
req_hold  in  8  override duration in ticks; 0 is treated as 1
req_ready  out  1  scheduler can accept an override
led_in  out  8  registered bus driving LEDs_mgmt.in
busy  out  1  high while an override owns the bus
tick  out  1  one-cycle pulse at each pattern tick

Behaviour:
- Reset (async, rst_n=0):
  - led_in=0x00, req_ready=0, busy=0, tick=0.
  - mode_r=STATIC, state=AUTO, prescaler=0.
  - cnt=0x00, shift=0x01 with direction LEFT, blink phase=ON.
  - req_ready first reads 1 in the first cycle after rst_n rises.
  - Reset mid-override aborts the override with no residue.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the cycle in which the count is TICK_DIV-1.
- Pattern engine (advances on tick in both AUTO and OVERRIDE):
  - STATIC: pattern=static_val, sampled every cycle.
  - COUNT: cnt+1 per tick, 8-bit wrap 0xFF->0x00.
  - SHIFT: one-hot value moves left each tick until 0x80, then right until 0x01, then left again. The endpoints are shown for one tick each; there is no double dwell.
  - BLINK: phase toggles each tick; pattern=static_val when ON, 0x00 when OFF.
- mode_valid at cycle N:
  - mode_r<=mode.
  - cnt/shift/direction/phase reinitialise to their reset values.
  - Prescaler clears to 0.
  - Applies even when mode equals mode_r.
  - If the prescaler was at terminal count in cycle N, tick still pulses in N but the pattern is not advanced.
- Arbiter FSM, states AUTO and OVERRIDE:
  - AUTO: req_ready=1. led_in<=pattern each cycle (1-cycle latency).
  - Accept when req_valid && req_ready:
    - latch req_data; hold=max(req_hold,1);
    - next state OVERRIDE; req_ready<=0; busy<=1;
    - led_in<=req_data in the next cycle.
  - OVERRIDE: led_in holds the latched value; hold decrements on each tick.
  - When tick occurs with hold==1: return to AUTO next cycle, with led_in<=current pattern, busy<=0, req_ready<=1.
  - req_valid during OVERRIDE is ignored and not queued.
- Simultaneous events:
  - mode_valid together with an accept: both take effect; the pattern reinitialises in the background.
  - mode_valid during OVERRIDE: the pattern reinitialises and the override output is unaffected. Because the prescaler clears, the current hold tick is stretched.
- Arithmetic: all pattern regs are 8-bit unsigned with silent wrap. hold is 8-bit and never underflows.

Decomposition:
- Shared header/package led_pkg:
  - MODE_STATIC/COUNT/SHIFT/BLINK 2-bit localparams;
  - ST_AUTO/ST_OVERRIDE encodings;
  - LED_W=8.
- Sub-module tick_prescaler (parameter TICK_DIV; ports clk, rst_n, clr, tick).
- The pattern engine and arbiter FSM stay in the top module.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release with mode_valid=0. Required: led_in=0x00, busy=0, req_ready=0 during reset, and req_ready=1 one cycle after release.
- COUNT wrap: mode_valid with mode=01 and TICK_DIV=4. Required: led_in 0x00,0x01,0x02,... changes once per 4 cycles. After forcing 256 ticks, 0xFF is followed by 0x00.
- SHIFT bounce: mode=10. Over 16 ticks led_in reads 0x01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02.
- BLINK: static_val=0xA5, mode=11. Required: led_in alternates 0xA5 and 0x00 every tick. Changing static_val to 0x3C mid-ON shows 0x3C in the next cycle.
- Override with COUNT running: req_valid, req_data=0x81, req_hold=2. Required:
  - req_ready drops and busy=1;
  - led_in=0x81 for exactly 2 ticks, then resumes the background count value, which advanced by 2;
  - a second req_valid during the override is ignored.
- Edge cases:
  - req_hold=0 produces a 1-tick override.
  - Asserting rst_n=0 mid-override returns led_in=0x00 immediately (asynchronously).
  - mode_valid coincident with an accept: the override shows first, then the new mode from its initial value.
